// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// opcodes, ALU/mux select encodings and the control FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_TRAP
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for memory states.
// Ports: clk, rst (sync, active-high), active (FSM in a memory state),
//        ready (mem_ready), timeout (limit reached with no ready).
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIM = WAIT_W'(MEM_WAIT_MAX - 1);

    logic [WAIT_W-1:0] cnt;

    // cnt holds cycles already waited; this cycle is wait number cnt+1.
    assign timeout = active && !ready && (cnt >= LIM);

    // Leaving a memory state or completing one always passes through a
    // clear, so every entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst || !active || ready || timeout)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Ports: clk, rst (sync, active-high), Opcode, mem_ready in; datapath
//   enables/selects, ALUOP, sticky mem_err and illegal_op out.
// Option: ILLEGAL_OP_TRAP_EN sends undefined opcodes to a held TRAP state.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOP,
    output logic       mem_err,
    output logic       illegal_op
);

    state_t     state, state_nx;
    logic [5:0] op_q;
    logic       mem_state;
    logic       timeout;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) ||
                       (state == S_MEMWR);

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX),
        .WAIT_W      (WAIT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .active (mem_state),
        .ready  (mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            op_q    <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE)
                op_q <= Opcode;
            if (timeout)
                mem_err <= 1'b1;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)
            illegal_op <= 1'b0;
        else if (state_nx == S_TRAP)
            illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH: begin
                if (mem_ready)
                    state_nx = S_DECODE;
                else if (timeout)
                    state_nx = S_FETCH;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXECUTE;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_nx = S_TRAP;
`else
                    default:      state_nx = S_FETCH;
`endif
                endcase
            end
            // Uses the opcode captured in DECODE, not the live IR field.
            S_MEMADR:  state_nx = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)
                    state_nx = S_MEMWB;
                else if (timeout)
                    state_nx = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready || timeout)
                    state_nx = S_FETCH;
            end
            S_EXECUTE: state_nx = S_ALUWB;
            S_ADDIEX:  state_nx = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                state_nx = S_FETCH;
            S_TRAP:    state_nx = S_TRAP;
            default:   state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        PCSrc    = PC_ALU;
        ALUOP    = ALUOP_ADD;
        unique case (state)
            S_FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:  ALUSrcB = SRCB_IMMSH;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD:   IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOP   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOP   = ALUOP_SUB;
                PCSrc   = PC_ALUOUT;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB:  RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = PC_JUMP;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset must never let a state-change strobe escape.
        if (rst) begin
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues the expected
// outputs of each cycle, a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

    typedef enum {F, D, MA, MR, MWB, MW, EX, AWB, BR, AX, AWB2, J, T} st_e;

    typedef struct packed {
        logic       pcw, br, iord, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, pcs, aop;
        logic       err, ill;
    } ov_t;

    typedef struct {
        ov_t   v;
        string tag;
    } exp_t;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, ALUOP;
    logic       mem_err, illegal_op;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15), .WAIT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .Opcode    (Opcode),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .PCSrc     (PCSrc),
        .ALUOP     (ALUOP),
        .mem_err   (mem_err),
        .illegal_op(illegal_op)
    );

    function automatic ov_t expect_of(st_e s, logic mr, logic r,
                                      logic err, logic ill);
        ov_t v;
        v = '0;
        case (s)
            F:    begin v.sb = 2'b01; v.irw = mr; v.pcw = mr; end
            D:    v.sb = 2'b11;
            MA:   begin v.sa = 1; v.sb = 2'b10; end
            MR:   v.iord = 1;
            MWB:  begin v.m2r = 1; v.rw = 1; end
            MW:   begin v.iord = 1; v.mw = 1; end
            EX:   begin v.sa = 1; v.aop = 2'b10; end
            AWB:  begin v.rd = 1; v.rw = 1; end
            BR:   begin v.sa = 1; v.aop = 2'b01; v.pcs = 2'b01; v.br = 1; end
            AX:   begin v.sa = 1; v.sb = 2'b10; end
            AWB2: v.rw = 1;
            J:    begin v.pcs = 2'b10; v.pcw = 1; end
            default: ;
        endcase
        if (r) begin
            v.pcw = 0; v.br = 0; v.mw = 0; v.irw = 0; v.rw = 0;
        end
        v.err = err;
        v.ill = ill;
        return v;
    endfunction

    task automatic cyc(input st_e s, input logic mr, input logic [5:0] op,
                       input logic err, input logic r, input logic ill);
        exp_t e;
        rst       = r;
        mem_ready = mr;
        Opcode    = op;
        e.v   = expect_of(s, mr, r, err, ill);
        e.tag = $sformatf("step%0d_%s", step, s.name());
        q.push_back(e);
        step++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_nowait(input st_e s, input logic [5:0] op);
        cyc(s, 1'b1, op, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            ov_t  a;
            e = q.pop_front();
            a = {PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                 RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOP, mem_err,
                 illegal_op};
            checks++;
            if (a !== e.v) begin
                failures++;
                $display("FAIL %s actual=%b required=%b", e.tag, a, e.v);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        Opcode    = RT;
        @(posedge clk);
        #1;
        // Reset held with mem_ready high: FETCH selects, no strobes.
        cyc(F, 1'b1, LW, 1'b0, 1'b1, 1'b0);

        // lw, 5 cycles
        run_nowait(F, LW); run_nowait(D, LW); run_nowait(MA, LW);
        run_nowait(MR, LW); run_nowait(MWB, LW);
        // R-type, 4 cycles
        run_nowait(F, RT); run_nowait(D, RT); run_nowait(EX, RT);
        run_nowait(AWB, RT);
        // beq, 3 cycles
        run_nowait(F, BEQ); run_nowait(D, BEQ); run_nowait(BR, BEQ);
        // addi, 4 cycles
        run_nowait(F, ADI); run_nowait(D, ADI); run_nowait(AX, ADI);
        run_nowait(AWB2, ADI);
        // j, 3 cycles
        run_nowait(F, JMP); run_nowait(D, JMP); run_nowait(J, JMP);

        // sw with 3 wait cycles in MEMWR
        run_nowait(F, SW); run_nowait(D, SW); run_nowait(MA, SW);
        for (int i = 0; i < 3; i++)
            cyc(MW, 1'b0, SW, 1'b0, 1'b0, 1'b0);
        cyc(MW, 1'b1, SW, 1'b0, 1'b0, 1'b0);

        // lw decoded, IR then changes to sw: still a load
        run_nowait(F, LW); run_nowait(D, LW); run_nowait(MA, SW);
        run_nowait(MR, SW); run_nowait(MWB, SW);

        // lw with mem_ready arriving exactly at the limit: no error
        run_nowait(F, LW); run_nowait(D, LW); run_nowait(MA, LW);
        for (int i = 0; i < 14; i++)
            cyc(MR, 1'b0, LW, 1'b0, 1'b0, 1'b0);
        cyc(MR, 1'b1, LW, 1'b0, 1'b0, 1'b0);
        run_nowait(MWB, LW);

        // lw timing out in MEMRD: abandoned, no write-back
        run_nowait(F, LW); run_nowait(D, LW); run_nowait(MA, LW);
        for (int i = 0; i < 15; i++)
            cyc(MR, 1'b0, LW, 1'b0, 1'b0, 1'b0);
        cyc(F, 1'b0, LW, 1'b1, 1'b0, 1'b0);
        cyc(F, 1'b0, LW, 1'b1, 1'b1, 1'b0);

        // FETCH starved for 15 cycles
        for (int i = 0; i < 15; i++)
            cyc(F, 1'b0, RT, 1'b0, 1'b0, 1'b0);
        cyc(F, 1'b0, RT, 1'b1, 1'b0, 1'b0);
        cyc(F, 1'b0, RT, 1'b1, 1'b1, 1'b0);
        cyc(F, 1'b0, RT, 1'b0, 1'b0, 1'b0);

        // rst in MEMRD aborts the load
        run_nowait(F, LW); run_nowait(D, LW); run_nowait(MA, LW);
        cyc(MR, 1'b0, LW, 1'b0, 1'b0, 1'b0);
        cyc(MR, 1'b1, LW, 1'b0, 1'b1, 1'b0);
        run_nowait(F, RT); run_nowait(D, RT); run_nowait(EX, RT);
        run_nowait(AWB, RT);

        // undefined opcode
        run_nowait(F, BAD); run_nowait(D, BAD);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 3; i++)
            cyc(T, 1'b1, BAD, 1'b0, 1'b0, 1'b1);
        cyc(T, 1'b1, BAD, 1'b0, 1'b1, 1'b1);
        run_nowait(F, JMP);
`else
        run_nowait(F, JMP);
`endif
        run_nowait(D, JMP); run_nowait(J, JMP);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS variant. Sequences one shared ALU, one shared memory port and the PC/IR/register-file enables across FETCH→DECODE→execute states.
- Drives the 2-bit ALUOp consumed by the existing ALU decoder: 00 add, 01 sub, 10 decode from funct.
- Adds a memory-ready handshake with a bounded wait counter.

Parameters:
- MEM_WAIT_MAX, 15: max cycles to wait for mem_ready in a memory state before declaring timeout (1..255).
- WAIT_W, 8: width of the wait counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  6  instr[31:26] from IR; sampled only in DECODE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load; datapath ANDs it with Zero.
- IorD  out  1  memory address source: 0=PC, 1=ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  register destination: 0=rt, 1=rd.
- MemtoReg  out  1  write-back data: 0=ALUOut, 1=MDR.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  ALU A operand: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B operand: 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- PCSrc  out  2  next-PC source: 00=ALUResult, 01=ALUOut, 10=jump target.
- ALUOP  out  2  to the ALU decoder.
- mem_err  out  1  sticky memory timeout flag.
- illegal_op  out  1  sticky undefined-opcode flag; driven 0 when the optional feature is compiled out.

Behaviour:
- Moore FSM. Outputs decode from the state register only, except PCWrite/IRWrite in FETCH, which are gated by mem_ready. Outputs not listed for a state are 0.
- Reset: state←FETCH, wait counter←0, mem_err←0, illegal_op←0. While rst=1, PCWrite, Branch, MemWrite, IRWrite and RegWrite are forced to 0. rst asserted mid-instruction aborts it; the next cycle is FETCH.
- State outputs:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=00, PCSrc=00, IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=00.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1, held through the wait.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOP=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOP=00.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
  - TRAP: all outputs 0 (optional feature only).
- Transitions:
  - FETCH→DECODE when mem_ready.
  - DECODE, by Opcode: 100011 lw / 101011 sw→MEMADR; 000000→EXECUTE; 000100→BRANCH; 001000→ADDIEX; 000010→JUMP; other→see Optional Feature.
  - MEMADR→MEMRD (lw) or MEMWR (sw). Opcode is registered in DECODE, so later IR changes have no effect.
  - MEMRD→MEMWB on mem_ready.
  - MEMWR→FETCH on mem_ready.
  - EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- Latency with mem_ready tied 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Wait counter (memory states FETCH, MEMRD, MEMWR):
  - Clears on entry to any memory state and on mem_ready.
  - Increments each cycle in a memory state while mem_ready=0; saturates.
  - When it reaches MEM_WAIT_MAX with mem_ready=0: mem_err←1 (sticky until rst) and the state goes to FETCH. The instruction is abandoned; no RegWrite/PCWrite for it.
  - mem_ready arriving in the same cycle as the limit wins: normal transition, no error.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined: an undefined opcode in DECODE→TRAP. TRAP sets illegal_op=1 and is held until rst, with all enables 0.
- Undefined: an undefined opcode in DECODE→FETCH (executes as a 2-cycle NOP); illegal_op is tied 0.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), ALUOP encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), ALUSrcB/PCSrc encodings, and the state enum typedef.
- One natural sub-module: mem_wait_timer (the counter plus timeout compare). The FSM and output decode stay in this module.

Test Plan:
- mem_ready=1, Opcode=100011 → states FETCH,DECODE,MEMADR,MEMRD,MEMWB over 5 cycles. MEMADR shows ALUSrcB=10, ALUOP=00; MEMWB shows RegWrite=1, MemtoReg=1.
- Opcode=000000 → EXECUTE with ALUOP=10, ALUSrcA=1, ALUSrcB=00, then ALUWB with RegDst=1, RegWrite=1; back in FETCH at cycle 5.
- Opcode=000100 → BRANCH on cycle 3 with ALUOP=01, Branch=1, PCSrc=01, PCWrite=0.
- sw with mem_ready low 3 cycles in MEMWR → MemWrite held 4 cycles, FETCH after mem_ready; mem_err=0.
- mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 → IRWrite never pulses, mem_err=1 after 15 cycles; rst pulse clears it.
- rst asserted in MEMRD → next cycle FETCH, all enables 0 during rst. With ILLEGAL_OP_TRAP_EN, Opcode=111111 → TRAP with illegal_op=1, held until rst.
